seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50000, clock cycles per digit slot (blank phase plus show phase); legal range 2..2^20.
REQ-002 SHALL provide parameter BLANK_CYC, default 500, blanking cycles at the start of each slot; legal range 0..CLK_DIV-1.
REQ-003 SHALL have port sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable  input  1  high = scan display, low = all digits dark.
REQ-006 SHALL have ports seg0..seg5  input  7 each  active-low segment patterns (gfedcba) for digits 0..5.
REQ-007 SHALL have port dp_in  input  6  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port upd_req  input  1  requester asks for seg0..seg5/dp_in to be loaded into the shadow registers.
REQ-009 SHALL have port upd_ack  output  1  one-cycle pulse confirming a shadow load.
REQ-010 SHALL have port seg_bus  output  7  active-low shared segment bus.
REQ-011 SHALL have port dp_n  output  1  active-low shared decimal point.
REQ-012 SHALL have port dig_sel  output  6  active-low one-hot digit select; 6'b111111 = none.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each complete 6-digit scan.

Function
REQ-014 SHALL implement states IDLE, BLANK, SHOW, with a slot counter cnt (0..CLK_DIV-1) and a digit index idx (0..5).
REQ-015 IDLE: SHALL drive dig_sel=6'b111111, seg_bus=7'h7F, dp_n=1, and hold cnt=0, idx=0.
REQ-016 IDLE->BLANK SHALL occur on the edge where enable=1; if BLANK_CYC=0, the transition SHALL go directly to SHOW.
REQ-017 BLANK: SHALL drive dig_sel=6'b111111, seg_bus=7'h7F, dp_n=1; BLANK->SHOW SHALL occur on the edge where cnt=BLANK_CYC-1.
REQ-018 SHOW: SHALL drive dig_sel[idx]=0 with all other bits 1, seg_bus=shadow_seg[idx], and dp_n=~shadow_dp[idx].
REQ-019 At cnt=CLK_DIV-1 in SHOW, the next edge SHALL set cnt=0 and idx=(idx==5)?0:idx+1, and enter BLANK (or SHOW if BLANK_CYC=0).
REQ-020 cnt SHALL increment by 1 every cycle in BLANK and SHOW, wrapping only per REQ-019.
REQ-021 All outputs except upd_ack and frame_done SHALL be decoded combinationally from state, idx and the shadow registers, with zero added latency.
REQ-022 A frame boundary SHALL be the cycle in SHOW where idx=5 and cnt=CLK_DIV-1.
REQ-023 frame_done SHALL be a registered pulse, high for exactly the one cycle following a frame boundary.
REQ-024 upd_req SHALL be sampled only when upd_ack=0.
REQ-025 When sampled upd_req=1 in IDLE or at a frame boundary, the shadow registers SHALL capture seg0..seg5 and dp_in on that edge, and upd_ack SHALL be 1 for exactly the next cycle.
REQ-026 The shadow registers SHALL NOT change at any other time, so a frame never mixes old and new data.
REQ-027 A requester SHALL hold upd_req and its data stable until upd_ack; if upd_req is still 1 after upd_ack, the next load SHALL wait for the next qualifying cycle.
REQ-028 If enable=0 is sampled in BLANK or SHOW, the next state SHALL be IDLE with cnt=0 and idx=0; no frame_done is issued for the aborted frame.
REQ-029 If enable falls on a frame-boundary edge with upd_req=1, the load and upd_ack SHALL still occur and frame_done SHALL still pulse.

Reset
REQ-030 While sys_rst_n=0 at a clock edge: state=IDLE, cnt=0, idx=0, shadow_seg[0..5]=7'h7F, shadow_dp=6'b000000, upd_ack=0, frame_done=0.
REQ-031 Outputs SHALL be at their IDLE values from the first edge with reset asserted, including when reset is asserted mid-frame; there is no asynchronous reset path.

Verification (CLK_DIV=8, BLANK_CYC=2 unless stated)
REQ-032 Reset, then enable=1 with shadow loaded as seg0=7'h40, seg1=7'h79 -> per slot: 2 cycles dig_sel=3F, then 6 cycles dig_sel=3E/seg_bus=40, then 2 blank, then 6 cycles dig_sel=3D/seg_bus=79; a full frame is 48 cycles.
REQ-033 frame_done -> exactly one pulse every 48 cycles, in the cycle after idx=5 and cnt=7.
REQ-034 upd_req=1 raised mid-frame with new seg0=7'h24 -> no shadow change until the frame boundary; upd_ack pulses once, and the next frame shows 7'h24 on digit 0.
REQ-035 enable dropped during SHOW of idx=3 -> dig_sel=3F and seg_bus=7F on the next cycle; re-enable -> scan restarts at idx 0 with BLANK.
REQ-036 BLANK_CYC=0, CLK_DIV=2 -> no all-off cycles; dig_sel steps 3E,3E,3D,3D,...; sys_rst_n=0 mid-scan -> IDLE outputs and shadow=7F on the next edge.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 6-digit seven-segment scan controller with per-slot blanking
// and frame-synchronous shadow register loading.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  input  logic [6:0] seg5,
  input  logic [5:0] dp_in,
  input  logic       upd_req,
  output logic       upd_ack,
  output logic [6:0] seg_bus,
  output logic       dp_n,
  output logic [5:0] dig_sel,
  output logic       frame_done
);

  localparam int            CW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;
  localparam bit            HAS_BLANK  = (BLANK_CYC > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [6:0]    shadow_seg_r [6];
  logic [5:0]    shadow_dp_r;
  logic          upd_ack_r;
  logic          frame_done_r;
  logic          frame_end_s;
  logic          load_s;

  // State, counters and shadow registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      idx_r        <= 3'd0;
      for (int i = 0; i < 6; i++) shadow_seg_r[i] <= 7'h7F;
      shadow_dp_r  <= 6'b000000;
      upd_ack_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      upd_ack_r    <= load_s;
      frame_done_r <= frame_end_s;
      if (load_s) begin
        shadow_seg_r[0] <= seg0;
        shadow_seg_r[1] <= seg1;
        shadow_seg_r[2] <= seg2;
        shadow_seg_r[3] <= seg3;
        shadow_seg_r[4] <= seg4;
        shadow_seg_r[5] <= seg5;
        shadow_dp_r     <= dp_in;
      end else begin
        shadow_dp_r <= shadow_dp_r;
      end
    end
  end

  // Next-state, slot counter and load qualification
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    frame_end_s = (state_r == ST_SHOW) && (idx_r == 3'd5) && (cnt_r == CNT_LAST);
    // Loads only land between frames so a scan never mixes old and new data.
    load_s      = upd_req && !upd_ack_r && ((state_r == ST_IDLE) || frame_end_s);
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        idx_s = 3'd0;
        if (enable) begin
          state_s = HAS_BLANK ? ST_BLANK : ST_SHOW;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          idx_s   = 3'd0;
        end else if (cnt_r == BLANK_LAST) begin
          state_s = ST_SHOW;
          cnt_s   = cnt_r + CW'(1);
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          idx_s   = 3'd0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = HAS_BLANK ? ST_BLANK : ST_SHOW;
          cnt_s   = '0;
          idx_s   = (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Display decode, zero latency from state and shadow contents
  always_comb begin
    dig_sel = 6'b111111;
    seg_bus = 7'h7F;
    dp_n    = 1'b1;
    case (state_r)
      ST_SHOW: begin
        if (idx_r <= 3'd5) begin
          dig_sel = ~(6'b000001 << idx_r);
          seg_bus = shadow_seg_r[idx_r];
          dp_n    = ~shadow_dp_r[idx_r];
        end else begin
          dig_sel = 6'b111111;
        end
      end
      default: begin
        dig_sel = 6'b111111;
      end
    endcase
  end

  assign upd_ack    = upd_ack_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (8/2 and 2/0 timing) share stimulus
// and are checked every cycle against a time-in-frame reference model.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] seg_in [6];
  logic [5:0] dp_in;
  logic       upd_req;

  logic       ack [2];
  logic [6:0] sb  [2];
  logic       dpn [2];
  logic [5:0] ds  [2];
  logic       fd  [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  localparam int CD [2] = '{8, 2};
  localparam int BC [2] = '{2, 0};

  // Reference model: a running flag plus cycles since the scan started.
  bit         run   [2];
  int         t     [2];
  logic [6:0] m_seg [2][6];
  logic [5:0] m_dp  [2];
  bit         m_ack [2];
  bit         m_fd  [2];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable),
    .seg0(seg_in[0]), .seg1(seg_in[1]), .seg2(seg_in[2]),
    .seg3(seg_in[3]), .seg4(seg_in[4]), .seg5(seg_in[5]),
    .dp_in(dp_in), .upd_req(upd_req), .upd_ack(ack[0]),
    .seg_bus(sb[0]), .dp_n(dpn[0]), .dig_sel(ds[0]), .frame_done(fd[0]));

  seg_scan_ctrl #(.CLK_DIV(2), .BLANK_CYC(0)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable),
    .seg0(seg_in[0]), .seg1(seg_in[1]), .seg2(seg_in[2]),
    .seg3(seg_in[3]), .seg4(seg_in[4]), .seg5(seg_in[5]),
    .dp_in(dp_in), .upd_req(upd_req), .upd_ack(ack[1]),
    .seg_bus(sb[1]), .dp_n(dpn[1]), .dig_sel(ds[1]), .frame_done(fd[1]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d] got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Model update at each rising edge from pre-edge inputs and model state
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int fr;
      bit bnd;
      bit ld;
      fr = 6 * CD[k];
      if (!rst_n) begin
        run[k]   <= 1'b0;
        t[k]     <= 0;
        for (int j = 0; j < 6; j++) m_seg[k][j] <= 7'h7F;
        m_dp[k]  <= 6'b0;
        m_ack[k] <= 1'b0;
        m_fd[k]  <= 1'b0;
      end else begin
        bnd = run[k] && ((t[k] % fr) == fr - 1);
        ld  = (!run[k] || bnd) && upd_req && !m_ack[k];
        if (ld) begin
          for (int j = 0; j < 6; j++) m_seg[k][j] <= seg_in[j];
          m_dp[k] <= dp_in;
        end
        m_ack[k] <= ld;
        m_fd[k]  <= bnd;
        if (!run[k]) begin
          if (enable) begin
            run[k] <= 1'b1;
            t[k]   <= 0;
          end
        end else if (!enable) begin
          run[k] <= 1'b0;
        end else begin
          t[k] <= t[k] + 1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [5:0] eds;
        logic [6:0] esb;
        logic       edp;
        int ph, slot, off;
        eds = 6'h3F; esb = 7'h7F; edp = 1'b1;
        if (run[k]) begin
          ph   = t[k] % (6 * CD[k]);
          slot = ph / CD[k];
          off  = ph % CD[k];
          if (off >= BC[k]) begin
            eds = 6'h3F & ~(6'd1 << slot);
            esb = m_seg[k][slot];
            edp = ~m_dp[k][slot];
          end
        end
        chk("dig_sel", k, 32'(ds[k]), 32'(eds));
        chk("seg_bus", k, 32'(sb[k]), 32'(esb));
        chk("dp_n", k, 32'(dpn[k]), 32'(edp));
        chk("upd_ack", k, 32'(ack[k]), 32'(m_ack[k]));
        chk("frame_done", k, 32'(fd[k]), 32'(m_fd[k]));
      end
    end
  end

  initial begin
    int w;
    rst_n = 1'b0; enable = 1'b0; upd_req = 1'b0; dp_in = 6'b0;
    for (int j = 0; j < 6; j++) seg_in[j] = 7'h7F;
    tick(3);
    chk_en = 1'b1;
    chk("rst_dig_sel", 0, 32'(ds[0]), 32'h3F);
    chk("rst_seg_bus", 0, 32'(sb[0]), 32'h7F);
    chk("rst_ack", 0, 32'(ack[0]), 32'h0);
    chk("rst_fd", 1, 32'(fd[1]), 32'h0);

    // Load from IDLE, then start scanning
    rst_n = 1'b1; seg_in[0] = 7'h40; seg_in[1] = 7'h79; dp_in = 6'b000010; upd_req = 1'b1;
    tick(1);
    chk("idle_ack", 0, 32'(ack[0]), 32'h1);
    upd_req = 1'b0; enable = 1'b1;
    tick(1);
    chk("first_blank", 0, 32'(ds[0]), 32'h3F);
    chk("noblank_d0", 1, 32'(ds[1]), 32'h3E);
    chk("noblank_s0", 1, 32'(sb[1]), 32'h40);
    tick(2);
    chk("show_d0", 0, 32'(ds[0]), 32'h3E);
    chk("show_s0", 0, 32'(sb[0]), 32'h40);
    chk("noblank_d1", 1, 32'(ds[1]), 32'h3D);
    chk("dp1_lit", 1, 32'(dpn[1]), 32'h0);
    tick(6);
    chk("slot1_blank", 0, 32'(ds[0]), 32'h3F);
    tick(2);
    chk("show_d1", 0, 32'(ds[0]), 32'h3D);
    chk("show_s1", 0, 32'(sb[0]), 32'h79);
    tick(37);
    chk("fd_before", 0, 32'(fd[0]), 32'h0);
    tick(1);
    chk("fd_pulse", 0, 32'(fd[0]), 32'h1);

    // Mid-frame update request waits for the frame boundary
    seg_in[0] = 7'h24; upd_req = 1'b1;
    tick(1);
    chk("no_early_ack", 0, 32'(ack[0]), 32'h0);
    w = 0;
    while (!ack[0] && w < 100) begin tick(1); w++; end
    chk("ack_seen", 0, 32'(ack[0]), 32'h1);
    upd_req = 1'b0;
    tick(2);
    chk("new_d0", 0, 32'(ds[0]), 32'h3E);
    chk("new_s0", 0, 32'(sb[0]), 32'h24);

    // Disable during digit 3, then restart
    w = 0;
    while (ds[0] != 6'h37 && w < 100) begin tick(1); w++; end
    chk("reach_idx3", 0, 32'(ds[0]), 32'h37);
    enable = 1'b0;
    tick(1);
    chk("abort_ds", 0, 32'(ds[0]), 32'h3F);
    chk("abort_sb", 0, 32'(sb[0]), 32'h7F);
    enable = 1'b1;
    tick(1);
    chk("restart_blank", 0, 32'(ds[0]), 32'h3F);
    tick(2);
    chk("restart_d0", 0, 32'(ds[0]), 32'h3E);

    // Reset in the middle of a scan
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_ds", 1, 32'(ds[1]), 32'h3F);
    chk("midrst_sb", 1, 32'(sb[1]), 32'h7F);
    chk("midrst_ds", 0, 32'(ds[0]), 32'h3F);
    rst_n = 1'b1;
    tick(1);
    chk("postrst_ds", 1, 32'(ds[1]), 32'h3E);
    chk("postrst_sb", 1, 32'(sb[1]), 32'h7F);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      rst_n = ($urandom_range(0, 499) != 0);
      if (upd_req && ack[0]) begin
        upd_req = 1'b0;
      end else if (!upd_req && $urandom_range(0, 29) == 0) begin
        for (int j = 0; j < 6; j++) seg_in[j] = 7'($urandom);
        dp_in = 6'($urandom);
        upd_req = 1'b1;
      end
      tick(1);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
